mem_arbiter: RTL
================

// Module: mem_arbiter
//
// PURPOSE
// - Merges the pipeline's imem (read-only) and dmem (read/write) ports onto one
//   unified memory port. Sits directly downstream of the cpu memory ports and
//   upstream of the memory model or cache.
// - One outstanding request. dmem has priority. A starvation guard forces an
//   imem grant after a bounded number of dmem grants.
//
// PARAMETERS
// - STARVE_LIMIT  4  max consecutive dmem grants while imem waits; 0 = guard off
//
// PORTS
// clk          in   1   clock
// rst          in   1   reset: synchronous, active-high
// imem_addr    in   32  instruction fetch address
// imem_rmask   in   4   fetch byte mask; !=0 means request present
// imem_rdata   out  32  fetch data, valid when imem_resp=1
// imem_resp    out  1   one-cycle fetch completion pulse
// dmem_addr    in   32  data address
// dmem_rmask   in   4   load byte mask
// dmem_wmask   in   4   store byte mask; request present if rmask|wmask !=0
// dmem_wdata   in   32  store data
// dmem_rdata   out  32  load data, valid when dmem_resp=1
// dmem_resp    out  1   one-cycle data completion pulse
// mem_addr     out  32  unified address, always {addr[31:2],2'b00}
// mem_rmask    out  4   unified read mask (registered)
// mem_wmask    out  4   unified write mask (registered)
// mem_wdata    out  32  unified write data (registered)
// mem_rdata    in   32  unified read data
// mem_resp     in   1   one-cycle completion from memory
// spurious     out  1   pulse: mem_resp arrived while IDLE (ignored)
//
// BEHAVIOUR
// - Requester contract: hold addr, masks and wdata stable from assertion until
//   its resp pulse. The requester may change or drop the request in the cycle
//   after the resp pulse.
// - FSM states: IDLE, BUSY_I, BUSY_D. Reset enters IDLE.
//   On reset: mem_* masks = 0, mem_addr = 0, mem_wdata = 0, both resp = 0,
//   rdata outputs = 0, spurious = 0, starvation counter = 0.
// - IDLE, request selection in priority order:
//   1. Guard tripped (STARVE_LIMIT>0, cnt==STARVE_LIMIT) and imem pending ->
//      grant imem.
//   2. Otherwise dmem pending -> grant dmem.
//   3. Otherwise imem pending -> grant imem.
//   4. Otherwise stay in IDLE.
// - Grant in cycle N: the winner's addr/masks/wdata are latched into the mem_*
//   registers. mem_* is driven from N+1 until the cycle mem_resp=1. imem grants
//   drive mem_wmask=0 and mem_wdata=0. dmem masks are forwarded unchanged
//   (both masks may be nonzero).
// - BUSY_x with mem_resp=1:
//   - x_resp=1 in the same cycle, x_rdata=mem_rdata (combinational path).
//   - mem_* masks clear at the next edge; FSM returns to IDLE.
//   - In BUSY_x, the other port's resp stays 0 and its rdata holds its
//     previous value.
// - Latency: a request seen in IDLE at cycle N, with memory responding k cycles
//   after the request is presented (k>=1), gives resp at cycle N+k. The next
//   grant happens no earlier than resp+1. Back-to-back throughput is one
//   access per k+1 cycles.
// - Starvation counter (width $clog2(STARVE_LIMIT+1)):
//   - dmem grant while imem pending: cnt+1, saturating at STARVE_LIMIT.
//   - dmem grant with imem idle: cnt=0.
//   - imem grant: cnt=0.
// - mem_resp while IDLE: dropped; spurious=1 that cycle; no port resp.
// - Reset mid-transaction: FSM returns to IDLE and masks clear next cycle.
//   Any late mem_resp for the aborted access is reported via spurious.
// - A request that appears in the same cycle as another port's resp is not
//   granted that cycle. It is arbitrated in IDLE the next cycle.
//
// TESTING
// 1. imem only, addr 0x1eceb000, rmask F, memory k=3 -> mem_rmask=F from N+1,
//    imem_resp at N+3, imem_rdata=mem_rdata, mem_wmask=0.
// 2. imem and dmem asserted together (dmem store 0x1ecec004, wmask 3,
//    wdata 0xdeadbeef) -> dmem granted first with mem_wmask=3 and
//    mem_wdata=0xdeadbeef; imem granted in the IDLE cycle after dmem_resp.
// 3. STARVE_LIMIT=4, dmem continuously pending with imem pending -> grant order
//    D,D,D,D,I,D,...; cnt returns to 0 after the imem grant.
// 4. dmem addr 0x1ecec007 with rmask 8 -> mem_addr=0x1ecec004, mem_rmask=8.
// 5. Reset asserted in BUSY_D before mem_resp, then mem_resp=1 two cycles
//    later -> no dmem_resp, spurious=1, masks=0, FSM in IDLE.
// 6. Random requests with random k in 1..8 -> every request gets exactly one
//    resp, in grant order, with never more than one access outstanding at
//    the memory.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Merges the pipeline's instruction port (read-only) and data port
// (read/write) onto one unified memory port. Only one access is ever
// outstanding at the memory. The data port normally wins. A starvation guard
// hands the next grant to the instruction port after STARVE_LIMIT back-to-back
// data grants that were made while a fetch was waiting.
//
// Parameters
//   STARVE_LIMIT  max consecutive dmem grants while imem waits (0 = guard off)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   imem_addr/imem_rmask           fetch request (rmask != 0 means present)
//   imem_rdata/imem_resp           fetch data and one-cycle completion pulse
//   dmem_addr/rmask/wmask/wdata    data request (rmask|wmask != 0 means present)
//   dmem_rdata/dmem_resp           load data and one-cycle completion pulse
//   mem_addr/rmask/wmask/wdata     registered unified request, word aligned
//   mem_rdata/mem_resp             unified read data and completion pulse
//   spurious                       mem_resp seen with no access outstanding

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        spurious
);

    // A zero limit would give a zero-width counter, so keep one bit in that case.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      imem_rdata_q;
    logic [31:0]      dmem_rdata_q;
    logic             imem_pending;
    logic             dmem_pending;
    logic             guard_tripped;
    logic             grant_imem;
    logic             grant_dmem;
    logic             unused_addr_bits;

    // The unified port is word addressed, so the byte offset bits are dropped.
    assign unused_addr_bits = ^{imem_addr[1:0], dmem_addr[1:0]};

    // Grant selection, only meaningful in IDLE. The fetch wins when the guard
    // has tripped or when there is no data request at all.
    always_comb begin
        imem_pending  = |imem_rmask;
        dmem_pending  = |(dmem_rmask | dmem_wmask);
        guard_tripped = (STARVE_LIMIT > 0) && (starve_cnt == CNT_MAX);
        grant_imem    = (state == IDLE) && imem_pending && (guard_tripped || !dmem_pending);
        grant_dmem    = (state == IDLE) && dmem_pending && !grant_imem;
    end

    // Completions are passed straight through in the cycle the memory answers.
    // While reset is held nothing is reported, so an answer to an aborted
    // access can only surface later as spurious.
    assign imem_resp  = !rst && (state == BUSY_I) && mem_resp;
    assign dmem_resp  = !rst && (state == BUSY_D) && mem_resp;
    assign spurious   = !rst && (state == IDLE) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : imem_rdata_q;
    assign dmem_rdata = dmem_resp ? mem_rdata : dmem_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            mem_addr     <= 32'h0;
            mem_rmask    <= 4'h0;
            mem_wmask    <= 4'h0;
            mem_wdata    <= 32'h0;
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_imem) begin
                        state      <= BUSY_I;
                        starve_cnt <= '0;
                        mem_addr   <= {imem_addr[31:2], 2'b00};
                        mem_rmask  <= imem_rmask;
                        mem_wmask  <= 4'h0;
                        mem_wdata  <= 32'h0;
                    end else if (grant_dmem) begin
                        state     <= BUSY_D;
                        mem_addr  <= {dmem_addr[31:2], 2'b00};
                        mem_rmask <= dmem_rmask;
                        mem_wmask <= dmem_wmask;
                        mem_wdata <= dmem_wdata;
                        // Only data grants that bypass a waiting fetch count
                        // towards starvation; the count saturates at the limit.
                        if (imem_pending) begin
                            if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_resp) begin
                        state        <= IDLE;
                        mem_rmask    <= 4'h0;
                        mem_wmask    <= 4'h0;
                        imem_rdata_q <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_resp) begin
                        state        <= IDLE;
                        mem_rmask    <= 4'h0;
                        mem_wmask    <= 4'h0;
                        dmem_rdata_q <= mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
